// File: rtl/pomdp_episode_ctrl.sv
// Episode sequencer for a POMDP step pipeline: decide -> transition -> belief -> log,
// repeated for a latched horizon, with reward accumulation and a per-phase watchdog.
module pomdp_episode_ctrl #(
  parameter int STEP_W = 16,
  parameter int REW_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] horizon,
  input  logic [7:0]        timeout,
  output logic              dec_en,
  input  logic              dec_done,
  input  logic [1:0]        action,
  output logic              trn_en,
  input  logic              obs_done,
  input  logic              observation,
  input  logic              st_done,
  input  logic [15:0]       step_reward,
  output logic              bel_en,
  input  logic              bel_done,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [STEP_W-1:0] step_count,
  output logic [REW_W-1:0]  total_reward,
  output logic              log_valid,
  output logic [STEP_W-1:0] log_step,
  output logic [1:0]        log_action,
  output logic              log_obs
);

  typedef enum logic [2:0] {IDLE, DECIDE, TRANS, BELIEF, LOG, FINISH, ERROR} state_t;

  state_t            state_reg, state_next;
  logic [STEP_W-1:0] horizon_reg, horizon_next;
  logic [7:0]        timeout_reg, timeout_next;
  logic [7:0]        wd_reg, wd_next;
  logic [1:0]        action_reg, action_next;
  logic              obs_reg, obs_next;
  logic [15:0]       rew_reg, rew_next;
  logic              obs_seen_reg, obs_seen_next;
  logic              st_seen_reg, st_seen_next;
  logic              dec_en_reg, dec_en_next;
  logic              trn_en_reg, trn_en_next;
  logic              bel_en_reg, bel_en_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic [STEP_W-1:0] step_reg, step_next;
  logic [REW_W-1:0]  total_reg, total_next;
  logic              log_valid_reg, log_valid_next;
  logic [STEP_W-1:0] log_step_reg, log_step_next;
  logic [1:0]        log_action_reg, log_action_next;
  logic              log_obs_reg, log_obs_next;

  logic [7:0]        wd_inc;
  logic              wd_expire;
  logic [STEP_W-1:0] step_inc;
  logic [REW_W:0]    rew_sum;

  assign wd_inc    = wd_reg + 8'd1;
  assign wd_expire = (timeout_reg != 8'd0) && (wd_inc == timeout_reg);
  assign step_inc  = step_reg + STEP_W'(1);
  // One extra bit catches the carry that signals saturation.
  assign rew_sum   = {1'b0, total_reg} + (REW_W+1)'(rew_reg);

  always_comb begin
    state_next      = state_reg;
    horizon_next    = horizon_reg;
    timeout_next    = timeout_reg;
    wd_next         = wd_reg;
    action_next     = action_reg;
    obs_next        = obs_reg;
    rew_next        = rew_reg;
    obs_seen_next   = obs_seen_reg;
    st_seen_next    = st_seen_reg;
    step_next       = step_reg;
    total_next      = total_reg;
    err_next        = err_reg;
    log_step_next   = log_step_reg;
    log_action_next = log_action_reg;
    log_obs_next    = log_obs_reg;
    dec_en_next     = 1'b0;
    trn_en_next     = 1'b0;
    bel_en_next     = 1'b0;
    busy_next       = 1'b0;
    done_next       = 1'b0;
    log_valid_next  = 1'b0;

    case (state_reg)
      IDLE, ERROR: begin
        if (start) begin
          horizon_next = horizon;
          timeout_next = timeout;
          step_next    = '0;
          total_next   = '0;
          err_next     = 1'b0;
          state_next   = (horizon == '0) ? FINISH : DECIDE;
        end
      end
      DECIDE: begin
        if (dec_done) begin
          action_next = action;
          state_next  = TRANS;
        end else if (wd_expire) begin
          state_next = ERROR;
        end else begin
          wd_next = wd_inc;
        end
      end
      TRANS: begin
        if (obs_done) begin
          obs_seen_next = 1'b1;
          obs_next      = observation;
        end
        if (st_done) begin
          st_seen_next = 1'b1;
          rew_next     = step_reward;
        end
        if (obs_seen_next && st_seen_next) begin
          state_next = BELIEF;
        end else if (wd_expire) begin
          state_next = ERROR;
        end else begin
          wd_next = wd_inc;
        end
      end
      BELIEF: begin
        if (bel_done) begin
          state_next = LOG;
        end else if (wd_expire) begin
          state_next = ERROR;
        end else begin
          wd_next = wd_inc;
        end
      end
      LOG: begin
        step_next  = step_inc;
        total_next = rew_sum[REW_W] ? '1 : rew_sum[REW_W-1:0];
        state_next = (step_inc == horizon_reg) ? FINISH : DECIDE;
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Abort wins over any completion pulse and freezes the episode counters.
    if (abort && (state_reg != IDLE)) begin
      state_next = IDLE;
      step_next  = step_reg;
      total_next = total_reg;
      err_next   = err_reg;
    end

    if (state_next != TRANS) begin
      obs_seen_next = 1'b0;
      st_seen_next  = 1'b0;
    end
    if (state_next != state_reg) wd_next = '0;

    dec_en_next = (state_next == DECIDE) && (state_reg != DECIDE);
    trn_en_next = (state_next == TRANS)  && (state_reg != TRANS);
    bel_en_next = (state_next == BELIEF) && (state_reg != BELIEF);
    busy_next   = (state_next != IDLE) && (state_next != ERROR);
    done_next   = (state_next == FINISH);
    if (state_next == ERROR) err_next = 1'b1;

    if (state_next == LOG) begin
      log_valid_next  = 1'b1;
      log_step_next   = step_reg;
      log_action_next = action_reg;
      log_obs_next    = obs_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      horizon_reg    <= '0;
      timeout_reg    <= '0;
      wd_reg         <= '0;
      action_reg     <= '0;
      obs_reg        <= 1'b0;
      rew_reg        <= '0;
      obs_seen_reg   <= 1'b0;
      st_seen_reg    <= 1'b0;
      dec_en_reg     <= 1'b0;
      trn_en_reg     <= 1'b0;
      bel_en_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      step_reg       <= '0;
      total_reg      <= '0;
      log_valid_reg  <= 1'b0;
      log_step_reg   <= '0;
      log_action_reg <= '0;
      log_obs_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      horizon_reg    <= horizon_next;
      timeout_reg    <= timeout_next;
      wd_reg         <= wd_next;
      action_reg     <= action_next;
      obs_reg        <= obs_next;
      rew_reg        <= rew_next;
      obs_seen_reg   <= obs_seen_next;
      st_seen_reg    <= st_seen_next;
      dec_en_reg     <= dec_en_next;
      trn_en_reg     <= trn_en_next;
      bel_en_reg     <= bel_en_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
      step_reg       <= step_next;
      total_reg      <= total_next;
      log_valid_reg  <= log_valid_next;
      log_step_reg   <= log_step_next;
      log_action_reg <= log_action_next;
      log_obs_reg    <= log_obs_next;
    end
  end

  assign dec_en       = dec_en_reg;
  assign trn_en       = trn_en_reg;
  assign bel_en       = bel_en_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign err          = err_reg;
  assign step_count   = step_reg;
  assign total_reward = total_reg;
  assign log_valid    = log_valid_reg;
  assign log_step     = log_step_reg;
  assign log_action   = log_action_reg;
  assign log_obs      = log_obs_reg;

endmodule
